// File: rtl/demux1_2.sv
// Purpose: registered 1-to-2 valid/ready stream demux with per-channel holding register and delivered-beat counters.
// Latency: one cycle, a beat accepted at edge N is on out_d_* in cycle N+1; the outputs are registered.
// Backpressure: in_ready = destination channel empty or draining this cycle; each channel stalls independently.
// Optional feature: define DEMUX_ALT_EN to ignore sel and alternate strictly between channels 1,2,1,2.
module demux1_2 #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sel,
    output logic [DATA_W-1:0] out_1_data,
    output logic              out_1_valid,
    input  logic              out_1_ready,
    output logic [DATA_W-1:0] out_2_data,
    output logic              out_2_valid,
    input  logic              out_2_ready,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt_1,
    output logic [CNT_W-1:0]  cnt_2
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_t;

    chan_state_t st_1;
    chan_state_t st_2;
    logic        dest;      // 0 -> channel 1, 1 -> channel 2
    logic        drain_1;
    logic        drain_2;
    logic        load_1;
    logic        load_2;
    logic        accept;

`ifdef DEMUX_ALT_EN
    logic tgl;

    // Toggle bit picks the destination and flips on every accepted beat.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tgl <= 1'b0;
        end else if (accept) begin
            tgl <= ~tgl;
        end
    end

    assign dest = tgl;
`else
    assign dest = sel;
`endif

    assign out_1_valid = (st_1 == FULL);
    assign out_2_valid = (st_2 == FULL);
    assign drain_1     = out_1_valid & out_1_ready;
    assign drain_2     = out_2_valid & out_2_ready;

    // Only the destination channel gates the input; the other channel may be stalled freely.
    assign in_ready = dest ? ((st_2 == EMPTY) | drain_2)
                           : ((st_1 == EMPTY) | drain_1);
    assign accept   = in_valid & in_ready;
    assign load_1   = accept & ~dest;
    assign load_2   = accept &  dest;

    // Channel 1 holding-register FSM: data only changes on a load, so it is stable until drained.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            st_1       <= EMPTY;
            out_1_data <= '0;
        end else begin
            case (st_1)
                EMPTY: if (load_1) st_1 <= FULL;
                FULL:  if (drain_1 && !load_1) st_1 <= EMPTY;
                default: st_1 <= EMPTY;
            endcase
            if (load_1) begin
                out_1_data <= in_data;
            end
        end
    end

    // Channel 2 holding-register FSM, identical in behaviour to channel 1.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            st_2       <= EMPTY;
            out_2_data <= '0;
        end else begin
            case (st_2)
                EMPTY: if (load_2) st_2 <= FULL;
                FULL:  if (drain_2 && !load_2) st_2 <= EMPTY;
                default: st_2 <= EMPTY;
            endcase
            if (load_2) begin
                out_2_data <= in_data;
            end
        end
    end

    // Delivered-beat counters: clear wins over increment, increment wraps naturally.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_1 <= '0;
            cnt_2 <= '0;
        end else if (cnt_clr) begin
            cnt_1 <= '0;
            cnt_2 <= '0;
        end else begin
            if (drain_1) cnt_1 <= cnt_1 + CNT_W'(1);
            if (drain_2) cnt_2 <= cnt_2 + CNT_W'(1);
        end
    end

endmodule
